// File: rtl/lut_table_reader_pkg.sv
// ============================================================================
// Module   : lut_table_reader_pkg
// Purpose  : Shared types and geometry helpers for the LUT table reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lut_table_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    function automatic int calc_epw(input int word_w, input int out_bits);
        return word_w / out_bits;
    endfunction

    function automatic int calc_nwords(input int in_bits, input int epw);
        return (1 << in_bits) / epw;
    endfunction

    // Counter width that stays legal when the count collapses to a single value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int in_bits, input int out_bits, input int word_w);
        int epw;
        if (out_bits < 1 || word_w < out_bits) return 1'b0;
        if ((word_w % out_bits) != 0) return 1'b0;
        epw = word_w / out_bits;
        return (((1 << in_bits) % epw) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lut_table_reader_if.sv
// ============================================================================
// Module   : lut_table_reader_if
// Purpose  : Neuron probe port plus packed-word valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lut_table_reader_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int WORD_W   = 32
);
    logic [IN_BITS-1:0]  lut_addr;
    logic [OUT_BITS-1:0] lut_data;
    logic                m_valid;
    logic                m_ready;
    logic [WORD_W-1:0]   m_data;
    logic                m_last;

    modport master (
        output lut_addr,
        input  lut_data,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        input  lut_addr,
        output lut_data,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );
endinterface

`default_nettype wire

// File: rtl/lut_table_reader_packer.sv
// ============================================================================
// Module   : lut_entry_packer
// Purpose  : Slot-indexed pack register; exposes the word including the
//            entry being captured this cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_entry_packer #(
    parameter int OUT_BITS = 2,
    parameter int WORD_W   = 32,
    parameter int SLOT_W   = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_clear,
    input  wire logic                i_capture,
    input  wire logic [SLOT_W-1:0]   i_slot,
    input  wire logic [OUT_BITS-1:0] i_din,
    output logic      [WORD_W-1:0]   o_word_next
);

    logic [WORD_W-1:0] r_pack;
    logic [WORD_W-1:0] w_merged;

    // Merge the incoming entry combinationally so the final slot can be
    // loaded into the output word in the same cycle it is sampled.
    always_comb begin
        w_merged = r_pack;
        w_merged[int'(i_slot) * OUT_BITS +: OUT_BITS] = i_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack <= '0;
        end else if (i_clear) begin
            r_pack <= '0;
        end else if (i_capture) begin
            r_pack <= w_merged;
        end
    end

    assign o_word_next = w_merged;

endmodule

`default_nettype wire

// File: rtl/lut_table_reader.sv
// ============================================================================
// Module   : lut_table_reader
// Purpose  : Sweeps every input code of one LUT neuron, packs the sampled
//            outputs LSB-first and streams them over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_table_reader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int WORD_W   = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         start,
    output logic              busy,
    output logic              done,
    lut_table_reader_if.master bus
);
    import lut_table_reader_pkg::*;

    localparam int c_epw    = calc_epw(WORD_W, OUT_BITS);
    localparam int c_nwords = calc_nwords(IN_BITS, c_epw);
    localparam int c_k_w    = cnt_width(c_epw);
    localparam int c_w_w    = cnt_width(c_nwords);

    localparam logic [c_k_w-1:0] c_last_k    = c_k_w'(c_epw - 1);
    localparam logic [c_w_w-1:0] c_last_word = c_w_w'(c_nwords - 1);

    if (!params_ok(IN_BITS, OUT_BITS, WORD_W)) begin : g_param_check
        $error("lut_table_reader: WORD_W must be a multiple of OUT_BITS and EPW must divide 2**IN_BITS");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IN_BITS-1:0]   r_lut_addr;
    logic [c_k_w-1:0]     r_k;
    logic [c_w_w-1:0]     r_word;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_m_valid;
    logic [WORD_W-1:0]    r_m_data;
    logic                 r_m_last;

    logic                 w_k_last;
    logic                 w_word_last;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_load;
    logic                 w_hs;
    logic                 w_finish;
    logic [WORD_W-1:0]    w_pack_next;

    assign w_k_last    = (r_k == c_last_k);
    assign w_word_last = (r_word == c_last_word);
    assign w_finish    = w_hs & w_word_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)    w_state_nxt = ST_FILL;
            ST_FILL: if (w_k_last) w_state_nxt = ST_SEND;
            ST_SEND: if (w_hs)     w_state_nxt = w_word_last ? ST_IDLE : ST_FILL;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    // m_ready only matters while a word is actually being offered.
    always_comb begin
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_load    = 1'b0;
        w_hs      = 1'b0;
        case (r_state)
            ST_IDLE: w_accept = start;
            ST_FILL: begin
                w_capture = 1'b1;
                w_load    = w_k_last;
            end
            ST_SEND: w_hs = r_m_valid & bus.m_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lut_addr <= '0;
            r_k        <= '0;
            r_word     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_last   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_busy     <= 1'b1;
                r_lut_addr <= '0;
                r_k        <= '0;
                r_word     <= '0;
            end
            if (w_capture) begin
                r_lut_addr <= r_lut_addr + 1'b1;
                r_k        <= r_k + 1'b1;
            end
            if (w_load) begin
                r_m_data  <= w_pack_next;
                r_m_valid <= 1'b1;
                r_m_last  <= w_word_last;
            end
            if (w_hs) begin
                r_m_valid <= 1'b0;
                r_k       <= '0;
                if (w_finish) begin
                    r_m_last   <= 1'b0;
                    r_busy     <= 1'b0;
                    r_lut_addr <= '0;
                end else begin
                    r_word <= r_word + 1'b1;
                end
            end
        end
    end

    lut_entry_packer #(
        .OUT_BITS (OUT_BITS),
        .WORD_W   (WORD_W),
        .SLOT_W   (c_k_w)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_accept | w_hs),
        .i_capture   (w_capture),
        .i_slot      (r_k),
        .i_din       (bus.lut_data),
        .o_word_next (w_pack_next)
    );

    assign busy         = r_busy;
    assign done         = r_done;
    assign bus.lut_addr = r_lut_addr;
    assign bus.m_valid  = r_m_valid;
    assign bus.m_data   = r_m_data;
    assign bus.m_last   = r_m_last;

endmodule

`default_nettype wire
